// File: rtl/hfswr_rx_pkg.sv
// Shared definitions for the half-frame BRAM readout path: FSM encoding and
// output FIFO sizing.
package hfswr_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Enough room for every word that can be in the BRAM pipeline plus two,
    // so reads can issue every cycle while the stream keeps up.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on o_dout
// whenever o_empty is low.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_din,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_dout,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_full, w_push, w_pop;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == AW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
            if (w_pop)  r_rp <= (r_rp == AW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// Streams the just-completed half of a ping-pong capture BRAM out as one
// AXI-Stream half-frame each time the writer switches halves.
module bram_frame_reader
    import hfswr_rx_pkg::*;
#(
    parameter int POS_DIG = 13,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_half,
    output logic              bram_en,
    output logic [31:0]       bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              overrun
);
    localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int N_W        = POS_DIG - 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    rd_state_t        r_state, w_next;
    logic             r_wr_half_q, r_half, r_overrun;
    logic [N_W-1:0]   r_word_cnt;
    logic [RD_LAT:1]  r_vld_pipe, r_last_pipe;
    logic             w_toggle, w_issue, w_credit, w_last_word, w_pop, w_empty;
    logic [CNT_W-1:0] w_fifo_cnt, w_inflight;
    logic [DATA_W:0]  w_head;
    logic [31:0]      w_addr;

    assign w_toggle    = wr_half ^ r_wr_half_q;
    assign w_credit    = ({1'b0, w_fifo_cnt} + {1'b0, w_inflight}) < (CNT_W+1)'(FIFO_DEPTH);
    assign w_issue     = (r_state == ST_READ) && w_credit;
    assign w_last_word = (r_word_cnt == '1);

    always_comb begin
        w_inflight = '0;
        for (int i = 1; i <= RD_LAT; i++) w_inflight = w_inflight + CNT_W'(r_vld_pipe[i]);
    end

    always_comb begin
        w_addr            = '0;
        w_addr[POS_DIG]   = r_half;
        w_addr[POS_DIG-1:2] = r_word_cnt;
    end

    assign bram_en   = w_issue;
    assign bram_addr = (r_state == ST_READ) ? w_addr : 32'd0;
    assign busy      = (r_state != ST_IDLE);
    assign overrun   = r_overrun;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_toggle) w_next = ST_READ;
            ST_READ:  if (w_issue && w_last_word) w_next = ST_DRAIN;
            ST_DRAIN: if (m_tvalid && m_tready && m_tlast) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_half_q <= 1'b0;
            r_half      <= 1'b0;
            r_word_cnt  <= '0;
            r_overrun   <= 1'b0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_state     <= w_next;
            r_wr_half_q <= wr_half;
            if (r_state == ST_IDLE && w_toggle) begin
                r_half     <= r_wr_half_q;
                r_word_cnt <= '0;
            end else if (w_issue) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            // A switch mid-frame is flagged and dropped; the current frame runs on.
            if (w_toggle && r_state != ST_IDLE) r_overrun <= 1'b1;
            r_vld_pipe[1]  <= w_issue;
            r_last_pipe[1] <= w_issue & w_last_word;
            for (int i = 2; i <= RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    assign w_pop    = m_tvalid & m_tready;
    assign m_tvalid = ~w_empty;
    assign m_tdata  = w_head[DATA_W-1:0];
    assign m_tlast  = ~w_empty & w_head[DATA_W];

    sync_fifo #(.WIDTH(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld_pipe[RD_LAT]),
        .i_din   ({r_last_pipe[RD_LAT], bram_dout}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

endmodule

// File: tb/tb_bram_frame_reader.sv
// Directed bench for bram_frame_reader with POS_DIG=5 (8-word halves), RD_LAT=2.
module tb_bram_frame_reader;
    localparam int POS_DIG = 5;
    localparam int DATA_W  = 32;
    localparam int RD_LAT  = 2;
    localparam int FD      = RD_LAT + 2;
    localparam int NW      = 8;

    logic              clk = 1'b0;
    logic              rst, wr_half, m_tready;
    logic              bram_en, m_tvalid, m_tlast, busy, overrun;
    logic [31:0]       bram_addr;
    logic [DATA_W-1:0] bram_dout, m_tdata;
    logic [DATA_W-1:0] p1, p2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int outst = 0;
    int credit_bad = 0;
    int stall_issued = -1;
    logic [31:0] iq [$];
    logic [32:0] sq [$];
    int          scy [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_frame_reader #(.POS_DIG(POS_DIG), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .wr_half(wr_half),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .overrun(overrun)
    );

    // BRAM model: content is a tag OR'd with the byte address, two-cycle read.
    always @(posedge clk) begin
        p1 <= bram_en ? (32'hA500_0000 | bram_addr) : 32'hDEAD_BEEF;
        p2 <= p1;
    end
    assign bram_dout = p2;

    always @(negedge clk) begin
        if (rst) begin
            outst = 0;
        end else begin
            if (bram_en) begin
                iq.push_back(bram_addr);
                if (outst >= FD) credit_bad++;
            end
            if (m_tvalid && m_tready) begin
                sq.push_back({m_tlast, m_tdata});
                scy.push_back(cyc);
            end
            outst = outst + int'(bram_en) - int'(m_tvalid && m_tready);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready high; 1: ready ~30%; 2: ready low for the first 50 cycles
    task automatic run_frame(input logic h, input int mode, input int ovr_at, output int lat);
        int c;
        bit seen_busy;
        iq.delete(); sq.delete(); scy.delete();
        seen_busy = 0;
        lat = -1;
        c = 0;
        @(posedge clk); #1;
        wr_half  = h;
        m_tready = (mode != 2);
        while (c < 600) begin
            @(negedge clk);
            if (m_tvalid && lat < 0) lat = c;
            if (busy) seen_busy = 1;
            if (seen_busy && !busy) break;
            @(posedge clk); #1;
            c++;
            if (c == ovr_at) wr_half = ~wr_half;
            if (mode == 2 && c == 50) stall_issued = iq.size();
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = ($urandom_range(0, 99) < 30);
                default: m_tready = (c >= 50);
            endcase
        end
        chk("frame_timeout", (c >= 600), 0);
        m_tready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] base);
        chk({tag, "_nissue"}, iq.size(), NW);
        chk({tag, "_nword"}, sq.size(), NW);
        for (int k = 0; k < NW; k++) begin
            if (k < iq.size()) chk({tag, "_addr"}, iq[k], base + 4*k);
            if (k < sq.size()) begin
                chk({tag, "_data"}, sq[k][31:0], 32'hA500_0000 + base + 4*k);
                chk({tag, "_last"}, sq[k][32], (k == NW-1));
            end
        end
        chk({tag, "_credit"}, credit_bad, 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; wr_half = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", bram_en, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // 0->1 reads half 0
        run_frame(1'b1, 0, -1, lat);
        check_frame("f1", 32'h00);
        chk("f1_lat", lat, 4);
        if (scy.size() == NW) chk("f1_b2b", scy[NW-1] - scy[0], NW-1);
        chk("f1_busy", busy, 0);

        // 1->0 reads half 1
        run_frame(1'b0, 0, -1, lat);
        check_frame("f2", 32'h20);
        chk("f2_ovr", overrun, 0);

        // random backpressure
        run_frame(1'b1, 1, -1, lat);
        check_frame("f3", 32'h00);

        // second switch 3 cycles in: flagged, current frame unaffected
        run_frame(1'b0, 0, 3, lat);
        check_frame("f4", 32'h20);
        chk("f4_ovr", overrun, 1);
        repeat (20) @(negedge clk);
        chk("f4_nonew", iq.size(), NW);
        chk("f4_busy", busy, 0);

        // reset mid-frame with the stream stalled
        @(posedge clk); #1;
        wr_half = 1'b0; m_tready = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_tvalid", m_tvalid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ovr", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0; m_tready = 1'b1;
        sq.delete();
        repeat (10) @(negedge clk);
        chk("mr_stale", sq.size(), 0);
        run_frame(1'b1, 0, -1, lat);
        check_frame("f5", 32'h00);

        // long stall during READ
        run_frame(1'b0, 2, -1, lat);
        chk("f6_stall_issued", stall_issued, FD);
        check_frame("f6", 32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1);
    end

endmodule
